health_tracker: RTL

- Consumes the level-sensitive `health_update` collision flag produced by the collision handler and maintains the player's remaining health.
- Applies a post-hit invincibility window so that one sustained overlap costs one health point per window, not one per clock.
- Drives game-over status to the VGA/game-control logic.
- Sits between the collision handler and the display/score path, in the same clock domain.

---
 rtl/health_tracker.sv | 97 +++++++++
 1 files changed

// File: rtl/health_tracker.sv
// Player health tracker: counts accepted collision hits with a post-hit invincibility window.
// Latency: health, hit_pulse and state all update on the edge that samples the hit; outputs are registered.
// Backpressure: none; health_update is a level flag sampled every cycle and ignored outside PLAY.
module health_tracker #(
    parameter int HEALTH_W      = 3,
    parameter int MAX_HEALTH    = 5,
    parameter int IFRAME_CYCLES = 25000000,
    parameter int CNT_W         = 25
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                health_update,
    output logic [HEALTH_W-1:0] health,
    output logic                hit_pulse,
    output logic                invincible,
    output logic                playing,
    output logic                game_over
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        IFRAME = 2'd2,
        OVER   = 2'd3
    } state_t;

    localparam logic [HEALTH_W-1:0] HEALTH_FULL = HEALTH_W'(MAX_HEALTH);
    localparam logic [HEALTH_W-1:0] HEALTH_ONE  = HEALTH_W'(1);
    localparam logic [CNT_W-1:0]    IFRAME_LOAD = CNT_W'(IFRAME_CYCLES - 1);

    state_t              state, state_n;
    logic [HEALTH_W-1:0] health_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                hit_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            health    <= HEALTH_FULL;
            cnt       <= '0;
            hit_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            health    <= health_n;
            cnt       <= cnt_n;
            hit_pulse <= hit_n;
        end
    end

    always_comb begin
        state_n  = state;
        health_n = health;
        cnt_n    = cnt;
        hit_n    = 1'b0;
        case (state)
            IDLE: begin
                health_n = HEALTH_FULL;
                if (start) state_n = PLAY;
            end
            PLAY: begin
                if (health_update) begin
                    hit_n = 1'b1;
                    // Last point of health skips the invincibility window entirely.
                    if (health <= HEALTH_ONE) begin
                        health_n = '0;
                        state_n  = OVER;
                    end else begin
                        health_n = health - HEALTH_ONE;
                        cnt_n    = IFRAME_LOAD;
                        state_n  = IFRAME;
                    end
                end
            end
            IFRAME: begin
                if (cnt == '0) begin
                    state_n = PLAY;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            OVER: begin
                health_n = '0;
                if (start) begin
                    health_n = HEALTH_FULL;
                    state_n  = PLAY;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign invincible = (state == IFRAME);
    assign playing    = (state == PLAY) || (state == IFRAME);
    assign game_over  = (state == OVER);

endmodule
